admin_session_ctrl: RTL and testbench
=====================================

// Module: admin_session_ctrl
// PURPOSE
//  Sequences vending-machine administrator access: password login with retry lockout, idle logout,
//  and the admin operations (replenish one lane, clear all lanes, inquire a lane). Sits between
//  debounced panel inputs and the per-lane stock register file, which it drives via one write port.
// PARAMETERS
//  PASSWORD      5'b01011  admin password compared against pwd_sw
//  LANES         8         number of goods lanes (lane index is 3 bits)
//  CAP           7'd99     maximum goods per lane; replenish saturates here
//  MAX_TRIES     3         consecutive wrong entries that trigger lockout
//  LOCK_CYCLES   1000      lockout duration in clk cycles
//  IDLE_CYCLES   5000      admin idle cycles before automatic logout
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous, active-high reset
//  pwd_sw      in   5  password switches
//  pwd_go      in   1  1-cycle pulse: submit pwd_sw
//  logout      in   1  1-cycle pulse: end admin session
//  rep_go      in   1  1-cycle pulse: replenish lane_sel by rep_qty
//  clr_go      in   1  1-cycle pulse: clear all lanes to 0
//  inq_go      in   1  1-cycle pulse: report stock of lane_sel
//  lane_sel    in   3  target lane
//  rep_qty     in   7  quantity to add
//  stk_rdata   in   7  stock of stk_lane, combinational read from register file
//  en          out  1  admin session active
//  locked      out  1  lockout in progress
//  busy        out  1  multi-cycle op in progress; new *_go ignored
//  stk_lane    out  3  register-file address (read and write)
//  stk_we      out  1  write strobe, 1 cycle per write
//  stk_wdata   out  7  write data
//  inq_qty     out  7  last inquired stock value (held)
//  inq_valid   out  1  1-cycle pulse when inq_qty updates
// BEHAVIOUR
//  Reset: state=IDLE; en,locked,busy,stk_we,inq_valid=0; stk_lane,stk_wdata,inq_qty=0; tries=0.
//  All *_go inputs are single-cycle pulses from the debounce block; held levels not supported.
//  IDLE: pwd_go & pwd_sw==PASSWORD -> ADMIN next cycle (en=1), tries=0.
//        pwd_go & mismatch -> tries+1; tries reaching MAX_TRIES -> LOCK, tries=0. Other inputs ignored.
//  LOCK: locked=1, all inputs ignored for exactly LOCK_CYCLES cycles, then IDLE.
//  ADMIN: idle counter reloads IDLE_CYCLES on any *_go; reaching 0 -> IDLE (en=0).
//   Simultaneous pulses, priority: logout > clr_go > rep_go > inq_go; lower ones dropped.
//   logout -> IDLE next cycle.
//   inq_go -> stk_lane=lane_sel; next cycle inq_qty=stk_rdata, inq_valid=1; stays ADMIN.
//   rep_go -> REP_RD (stk_lane=lane_sel, busy=1) -> REP_WR: stk_we=1,
//     stk_wdata=min(stk_rdata+rep_qty, CAP), sum computed 8 bits wide -> ADMIN. Latency 2 cycles.
//   clr_go -> CLEAR: busy=1, stk_we=1, stk_wdata=0, stk_lane steps 0..LANES-1 one per cycle,
//     then ADMIN. Latency LANES cycles. Idle counter frozen while busy.
//   lane_sel>=LANES (when LANES<8): rep/inq ignored, no write issued.
//  busy=1: all *_go including logout ignored until return to ADMIN (ops never truncated).
//  rst mid-operation: immediate return to reset values; partial CLEAR left as is.
// CONFIGURATION
//  ADMIN_AUDIT_EN defined: adds outputs fail_cnt[7:0] (total wrong entries, saturating 255)
//   and op_cnt[7:0] (completed rep/clr ops, wraps), both 0 on reset.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  admin_pkg: state encoding (IDLE,ADMIN,REP_RD,REP_WR,CLEAR,LOCK), lane/qty width constants.
//  Sub-module admin_down_timer: loadable down-counter with zero flag, shared by LOCK and idle
//   timeout (only one is active per state).
// TESTING
//  1 pwd_sw=01011,pwd_go -> en=1 next cycle; tries=0.
//  2 three wrong pwd_go -> locked=1 for LOCK_CYCLES; correct pwd during lock ignored; then IDLE.
//  3 lane 2 holds 90, rep_qty=20, rep_go -> stk_we 2 cycles later with lane 2, wdata 99.
//  4 clr_go with rep_go same cycle -> 8 consecutive stk_we, lanes 0..7, wdata 0; no rep write.
//  5 ADMIN idle IDLE_CYCLES -> en=0; rst asserted mid-CLEAR at lane 3 -> all outputs at reset values.
//  6 inq_go lane 5 holding 17 -> inq_valid pulse, inq_qty=17 held afterwards.

Source files
------------

// File: rtl/admin_session_ctrl_pkg.sv
// Shared definitions for the administrator session controller.
//   - state_t  : controller state encoding
//   - LANE_W / QTY_W / SUM_W : lane index, stock quantity and widened sum widths
//   - sat_add  : replenish adder that clamps the 8-bit sum to the lane capacity
package admin_session_ctrl_pkg;

  localparam int LANE_W = 3;
  localparam int QTY_W  = 7;
  localparam int SUM_W  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADMIN  = 3'd1,
    REP_RD = 3'd2,
    REP_WR = 3'd3,
    CLEAR  = 3'd4,
    LOCK   = 3'd5
  } state_t;

  // The sum is formed one bit wider than a stock value so that two
  // in-range quantities can never wrap before the capacity clamp.
  function automatic logic [QTY_W-1:0] sat_add(input logic [QTY_W-1:0] a,
                                               input logic [QTY_W-1:0] b,
                                               input logic [QTY_W-1:0] cap);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, cap}) return cap;
    return sum[QTY_W-1:0];
  endfunction

endpackage

// File: rtl/admin_session_ctrl_if.sv
// Panel and stock-register-file signals of the administrator session controller.
//   master : panel/register-file side (drives pulses, lane/qty, stk_rdata)
//   slave  : controller side (drives session status and the register-file write port)
// With ADMIN_AUDIT_EN defined, fail_cnt/op_cnt audit counters are added.
interface admin_session_ctrl_if;
  import admin_session_ctrl_pkg::*;

  logic [4:0]        pwd_sw;
  logic              pwd_go;
  logic              logout;
  logic              rep_go;
  logic              clr_go;
  logic              inq_go;
  logic [LANE_W-1:0] lane_sel;
  logic [QTY_W-1:0]  rep_qty;
  logic [QTY_W-1:0]  stk_rdata;
  logic              en;
  logic              locked;
  logic              busy;
  logic [LANE_W-1:0] stk_lane;
  logic              stk_we;
  logic [QTY_W-1:0]  stk_wdata;
  logic [QTY_W-1:0]  inq_qty;
  logic              inq_valid;
`ifdef ADMIN_AUDIT_EN
  logic [7:0]        fail_cnt;
  logic [7:0]        op_cnt;
`endif

  modport master (
    output pwd_sw, pwd_go, logout, rep_go, clr_go, inq_go, lane_sel, rep_qty, stk_rdata,
`ifdef ADMIN_AUDIT_EN
    input  fail_cnt, op_cnt,
`endif
    input  en, locked, busy, stk_lane, stk_we, stk_wdata, inq_qty, inq_valid
  );

  modport slave (
    input  pwd_sw, pwd_go, logout, rep_go, clr_go, inq_go, lane_sel, rep_qty, stk_rdata,
`ifdef ADMIN_AUDIT_EN
    output fail_cnt, op_cnt,
`endif
    output en, locked, busy, stk_lane, stk_we, stk_wdata, inq_qty, inq_valid
  );

endinterface

// File: rtl/admin_session_ctrl_timer.sv
// admin_down_timer: loadable down-counter with a zero flag.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one, holding at zero
//   zero      : count is zero
module admin_down_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/admin_session_ctrl.sv
// admin_session_ctrl: vending-machine administrator session sequencer.
// Password login with retry lockout, idle logout, and the replenish /
// clear-all / inquire operations on the per-lane stock register file.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : admin_session_ctrl_if.slave -- panel pulses, lane/qty,
//              stk_rdata in; en/locked/busy, register-file write port,
//              inq_qty/inq_valid out.
// Optional feature macro ADMIN_AUDIT_EN: fail_cnt / op_cnt audit counters.
module admin_session_ctrl
  import admin_session_ctrl_pkg::*;
#(
  parameter logic [4:0]       PASSWORD    = 5'b01011,
  parameter int               LANES       = 8,
  parameter logic [QTY_W-1:0] CAP         = 7'd99,
  parameter int               MAX_TRIES   = 3,
  parameter int               LOCK_CYCLES = 1000,
  parameter int               IDLE_CYCLES = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  admin_session_ctrl_if.slave  bus
);

  localparam int TMR_W = 16;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_t            state;
  logic [TRY_W-1:0]  tries;
  logic              inq_pend;
  logic [QTY_W-1:0]  qty_hold;

  logic              pwd_ok;
  logic              any_go;
  logic              lane_ok;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_dec;
  logic              tmr_zero;

  assign pwd_ok  = (bus.pwd_sw == PASSWORD);
  assign any_go  = bus.pwd_go | bus.logout | bus.rep_go | bus.clr_go | bus.inq_go;
  assign lane_ok = (32'(bus.lane_sel) < LANES);

  // Timers load N-1 so that zero is observed on the N-th cycle of the
  // state, giving exactly N cycles of LOCK / idle ADMIN before leaving.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.pwd_go && pwd_ok) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(IDLE_CYCLES - 1);
        end else if (bus.pwd_go && (tries == TRY_W'(MAX_TRIES - 1))) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(LOCK_CYCLES - 1);
        end
      end
      LOCK:  tmr_dec = 1'b1;
      ADMIN: begin
        if (any_go) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(IDLE_CYCLES - 1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  admin_down_timer #(.CNT_W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tries         <= '0;
      inq_pend      <= 1'b0;
      qty_hold      <= '0;
      bus.en        <= 1'b0;
      bus.locked    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.stk_lane  <= '0;
      bus.stk_we    <= 1'b0;
      bus.stk_wdata <= '0;
      bus.inq_qty   <= '0;
      bus.inq_valid <= 1'b0;
    end else begin
      bus.stk_we    <= 1'b0;
      bus.inq_valid <= 1'b0;
      inq_pend      <= 1'b0;

      // Inquiry read completes one cycle after stk_lane was presented,
      // independent of what the FSM does in the meantime.
      if (inq_pend) begin
        bus.inq_qty   <= bus.stk_rdata;
        bus.inq_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.pwd_go) begin
            if (pwd_ok) begin
              state  <= ADMIN;
              bus.en <= 1'b1;
              tries  <= '0;
            end else if (tries == TRY_W'(MAX_TRIES - 1)) begin
              state      <= LOCK;
              bus.locked <= 1'b1;
              tries      <= '0;
            end else begin
              tries <= tries + 1'b1;
            end
          end
        end

        LOCK: begin
          if (tmr_zero) begin
            state      <= IDLE;
            bus.locked <= 1'b0;
          end
        end

        ADMIN: begin
          if (bus.logout) begin
            state  <= IDLE;
            bus.en <= 1'b0;
          end else if (bus.clr_go) begin
            state         <= CLEAR;
            bus.busy      <= 1'b1;
            bus.stk_we    <= 1'b1;
            bus.stk_wdata <= '0;
            bus.stk_lane  <= '0;
          end else if (bus.rep_go) begin
            if (lane_ok) begin
              state        <= REP_RD;
              bus.busy     <= 1'b1;
              bus.stk_lane <= bus.lane_sel;
              qty_hold     <= bus.rep_qty;
            end
          end else if (bus.inq_go) begin
            if (lane_ok) begin
              bus.stk_lane <= bus.lane_sel;
              inq_pend     <= 1'b1;
            end
          end else if (tmr_zero) begin
            state  <= IDLE;
            bus.en <= 1'b0;
          end
        end

        REP_RD: begin
          state         <= REP_WR;
          bus.stk_we    <= 1'b1;
          bus.stk_wdata <= sat_add(bus.stk_rdata, qty_hold, CAP);
        end

        REP_WR: begin
          state    <= ADMIN;
          bus.busy <= 1'b0;
        end

        CLEAR: begin
          if (32'(bus.stk_lane) == LANES - 1) begin
            state    <= ADMIN;
            bus.busy <= 1'b0;
          end else begin
            bus.stk_we    <= 1'b1;
            bus.stk_wdata <= '0;
            bus.stk_lane  <= bus.stk_lane + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ADMIN_AUDIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fail_cnt <= '0;
      bus.op_cnt   <= '0;
    end else begin
      if ((state == IDLE) && bus.pwd_go && !pwd_ok && (bus.fail_cnt != 8'hFF)) begin
        bus.fail_cnt <= bus.fail_cnt + 1'b1;
      end
      if ((state == REP_WR) ||
          ((state == CLEAR) && (32'(bus.stk_lane) == LANES - 1))) begin
        bus.op_cnt <= bus.op_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_admin_session_ctrl.sv
// Directed bench for admin_session_ctrl with a behavioural stock register file.
module tb_admin_session_ctrl;
  import admin_session_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  admin_session_ctrl_if bus ();

  admin_session_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stock register file: combinational read at stk_lane, one write port.
  logic [QTY_W-1:0]  mem [8];
  logic              pre_we;
  logic [LANE_W-1:0] pre_lane;
  logic [QTY_W-1:0]  pre_val;

  always @(posedge clk) begin
    if (pre_we) mem[pre_lane] <= pre_val;
    else if (bus.stk_we) mem[bus.stk_lane] <= bus.stk_wdata;
  end
  assign bus.stk_rdata = mem[bus.stk_lane];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic preload(input int lane, input int val);
    pre_lane = LANE_W'(lane);
    pre_val  = QTY_W'(val);
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic pwd(input logic [4:0] sw);
    bus.pwd_sw = sw;
    bus.pwd_go = 1'b1;
    tick();
    bus.pwd_go = 1'b0;
  endtask

  task automatic do_logout();
    bus.logout = 1'b1;
    tick();
    bus.logout = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    pre_we = 1'b0; pre_lane = '0; pre_val = '0;
    bus.pwd_sw = '0; bus.pwd_go = 1'b0; bus.logout = 1'b0;
    bus.rep_go = 1'b0; bus.clr_go = 1'b0; bus.inq_go = 1'b0;
    bus.lane_sel = '0; bus.rep_qty = '0;
    tick(); tick();

    check("rst_en", 32'(bus.en), 0);
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_we", 32'(bus.stk_we), 0);
    check("rst_lane", 32'(bus.stk_lane), 0);
    check("rst_wdata", 32'(bus.stk_wdata), 0);
    check("rst_inq_qty", 32'(bus.inq_qty), 0);
    check("rst_inq_valid", 32'(bus.inq_valid), 0);

    for (int i = 0; i < 8; i++) preload(i, i + 1);
    preload(2, 90);
    preload(5, 17);
    rst = 1'b0;
    tick();

    // Login with the correct password.
    pwd(5'b01011);
    check("login_en", 32'(bus.en), 1);
    check("login_locked", 32'(bus.locked), 0);

    // Inquire lane 5 (holds 17).
    bus.lane_sel = 3'd5; bus.inq_go = 1'b1;
    tick();
    bus.inq_go = 1'b0;
    check("inq_lane", 32'(bus.stk_lane), 5);
    check("inq_valid_early", 32'(bus.inq_valid), 0);
    tick();
    check("inq_valid", 32'(bus.inq_valid), 1);
    check("inq_qty", 32'(bus.inq_qty), 17);
    tick();
    check("inq_valid_pulse", 32'(bus.inq_valid), 0);
    check("inq_qty_held", 32'(bus.inq_qty), 17);

    // Replenish lane 2: 90 + 20 saturates to 99; logout during busy ignored.
    bus.lane_sel = 3'd2; bus.rep_qty = 7'd20; bus.rep_go = 1'b1;
    tick();
    bus.rep_go = 1'b0; bus.logout = 1'b1;
    check("rep_busy", 32'(bus.busy), 1);
    check("rep_rd_we", 32'(bus.stk_we), 0);
    check("rep_rd_lane", 32'(bus.stk_lane), 2);
    tick();
    bus.logout = 1'b0;
    check("rep_we", 32'(bus.stk_we), 1);
    check("rep_lane", 32'(bus.stk_lane), 2);
    check("rep_wdata_sat", 32'(bus.stk_wdata), 99);
    tick();
    check("rep_we_done", 32'(bus.stk_we), 0);
    check("rep_busy_done", 32'(bus.busy), 0);
    check("rep_mem2", 32'(mem[2]), 99);
    check("busy_logout_ignored", 32'(bus.en), 1);

    // Replenish lane 3: 4 + 10 = 14, no saturation.
    bus.lane_sel = 3'd3; bus.rep_qty = 7'd10; bus.rep_go = 1'b1;
    tick();
    bus.rep_go = 1'b0;
    tick();
    check("rep2_we", 32'(bus.stk_we), 1);
    check("rep2_wdata", 32'(bus.stk_wdata), 14);
    tick();

    // Clear-all wins over a simultaneous replenish.
    bus.lane_sel = 3'd6; bus.rep_qty = 7'd5;
    bus.clr_go = 1'b1; bus.rep_go = 1'b1;
    tick();
    bus.clr_go = 1'b0; bus.rep_go = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("clr_we", 32'(bus.stk_we), 1);
      check("clr_lane", 32'(bus.stk_lane), 32'(i));
      check("clr_wdata", 32'(bus.stk_wdata), 0);
      check("clr_busy", 32'(bus.busy), 1);
      tick();
    end
    check("clr_we_done", 32'(bus.stk_we), 0);
    check("clr_busy_done", 32'(bus.busy), 0);
    check("clr_en", 32'(bus.en), 1);
    for (int i = 0; i < 8; i++) check("clr_mem", 32'(mem[i]), 0);

`ifdef ADMIN_AUDIT_EN
    check("op_cnt", 32'(bus.op_cnt), 3);
`endif

    do_logout();
    check("logout_en", 32'(bus.en), 0);

    // Two wrong, then correct: login clears the retry count.
    pwd(5'b00000);
    pwd(5'b11111);
    check("two_wrong_unlocked", 32'(bus.locked), 0);
    pwd(5'b01011);
    check("relogin_en", 32'(bus.en), 1);
    do_logout();

    // Three wrong entries trigger lockout.
    pwd(5'b00000);
    pwd(5'b00001);
    check("pre_lock", 32'(bus.locked), 0);
    pwd(5'b00010);
    check("lock_start", 32'(bus.locked), 1);
`ifdef ADMIN_AUDIT_EN
    check("fail_cnt", 32'(bus.fail_cnt), 5);
`endif
    pwd(5'b01011);
    check("lock_pwd_ignored", 32'(bus.en), 0);
    check("lock_held", 32'(bus.locked), 1);
    repeat (997) tick();
    check("lock_998", 32'(bus.locked), 1);
    tick();
    check("lock_999", 32'(bus.locked), 1);
    tick();
    check("lock_end", 32'(bus.locked), 0);

    // Idle timeout: en drops exactly IDLE_CYCLES cycles after login.
    pwd(5'b01011);
    check("post_lock_login", 32'(bus.en), 1);
    repeat (4998) tick();
    check("idle_4998", 32'(bus.en), 1);
    tick();
    check("idle_4999", 32'(bus.en), 1);
    tick();
    check("idle_timeout", 32'(bus.en), 0);

    // Reset in the middle of CLEAR.
    for (int i = 0; i < 8; i++) preload(i, i + 10);
    pwd(5'b01011);
    bus.clr_go = 1'b1;
    tick();
    bus.clr_go = 1'b0;
    tick(); tick(); tick();
    check("midclr_lane3", 32'(bus.stk_lane), 3);
    rst = 1'b1;
    tick();
    check("midrst_en", 32'(bus.en), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_we", 32'(bus.stk_we), 0);
    check("midrst_lane", 32'(bus.stk_lane), 0);
    check("midrst_inq_qty", 32'(bus.inq_qty), 0);
    rst = 1'b0;
    tick();
    check("midrst_mem3", 32'(mem[3]), 0);
    check("midrst_mem4", 32'(mem[4]), 14);
    check("midrst_idle", 32'(bus.en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
